// File: rtl/jk_ff_driver.sv
// jk_ff_driver
// Drives the J/K inputs of WIDTH external JK flip-flops so that their Q outputs
// follow a stream of target words. Words are queued in a small FIFO. Each word is
// excitation-encoded against the current Q, applied for exactly one clock, and then
// checked against the Q feedback. Mismatches pulse err and are counted (saturating).
module jk_ff_driver #(
   parameter int WIDTH    = 4,
   parameter int DEPTH    = 4,
   parameter bit ENC_MODE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   input  logic [WIDTH-1:0] Q,
   output logic             busy,
   output logic             err,
   output logic [7:0]       err_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // IDLE waits for a word, DRIVE presents J/K for one clock, CHECK compares Q.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Target FIFO
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [WIDTH-1:0] w_head;

   // ---------------------------------------------------------------------------
   // Sequencer and datapath
   // ---------------------------------------------------------------------------
   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_tgt;
   logic [WIDTH-1:0] r_j;
   logic [WIDTH-1:0] r_k;
   logic [WIDTH-1:0] w_enc_j;
   logic [WIDTH-1:0] w_enc_k;
   logic [WIDTH-1:0] w_fill;
   logic             w_mismatch;
   logic             r_err;
   logic [7:0]       r_err_count;

   assign w_full   = (r_count == CNT_W'(DEPTH));
   assign w_empty  = (r_count == '0);
   // Ready is masked by reset so a word offered during reset is never captured.
   assign in_ready = ~w_full & ~rst;
   assign w_push   = in_valid & in_ready;
   assign w_head   = r_mem[r_rd_ptr];

   // Store incoming words at the tail.
   // NOTE: storage has no reset; an entry is only read after it has been written,
   // and leaving it out of reset lets it map onto plain RAM/register cells.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   // Advance pointers and occupancy; a simultaneous push and pop leaves the count as is.
   // NOTE: sequential state is always assigned with <= so every flop samples the
   // pre-edge values of its neighbours, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Excitation encoding of the FIFO head against the live Q.
   // A bit that already matches gets J=K=0 (hold). A bit that must rise gets J=1
   // and a bit that must fall gets K=1; the other input is the don't-care, filled
   // with 0 (pure set/reset) or 1 (toggle) depending on ENC_MODE.
   // ---------------------------------------------------------------------------
   assign w_fill  = {WIDTH{ENC_MODE}};
   assign w_enc_j = (~Q & w_head) | (w_fill &  Q & ~w_head);
   assign w_enc_k = ( Q & ~w_head) | (w_fill & ~Q &  w_head);

   // Q is only meaningful in CHECK: the flops sampled J/K on the edge that left DRIVE.
   assign w_mismatch = (r_state == S_CHECK) && (Q != r_tgt);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and pop decision; a word is taken whenever the sequencer can accept
   // one (IDLE, or CHECK finishing the previous word) and the FIFO held it before the edge.
   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_DRIVE;
            end
         end
         S_DRIVE: begin
            w_state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_DRIVE;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // J/K are nonzero only in the single cycle following a load, so the flops move
   // exactly once per word; reset forces them to 0 on the same edge so the flops hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_j   <= '0;
         r_k   <= '0;
         r_tgt <= '0;
      end else if (w_pop) begin
         r_j   <= w_enc_j;
         r_k   <= w_enc_k;
         r_tgt <= w_head;
      end else begin
         r_j   <= '0;
         r_k   <= '0;
      end
   end

   // Error pulse for one cycle after a failed CHECK, plus a saturating mismatch count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err       <= 1'b0;
         r_err_count <= 8'd0;
      end else begin
         r_err <= w_mismatch;
         if (w_mismatch && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
         end
      end
   end

   assign J         = r_j;
   assign K         = r_k;
   assign err       = r_err;
   assign err_count = r_err_count;
   assign busy      = (r_state != S_IDLE) | ~w_empty;

endmodule
